// File: rtl/muxn_rr_pkg.sv
// mux_pkg: mode encoding and default sizes shared by muxn_rr and its bench
package mux_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_N = 4;
  typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mode_e;
endpackage

// File: rtl/muxn_rr_if.sv
// muxn_rr_if: channel inputs, select controls and registered output of muxn_rr
interface muxn_rr_if #(
  parameter int WIDTH = 32,
  parameter int N = 4
);
  logic                        mode;
  logic [$clog2(N)-1:0]        sel;
  logic [N-1:0]                in_valid;
  logic [N-1:0][WIDTH-1:0]     in_data;
  logic [N-1:0]                in_ready;
  logic                        out_valid;
  logic [WIDTH-1:0]            out_data;
  logic [$clog2(N)-1:0]        out_ch;
  logic                        out_ready;
  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/muxn_rr_rr_arbiter.sv
// rr_arbiter: one-hot grant of the first requester above last, wrapping around
import mux_pkg::*;
module rr_arbiter #(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] idx;
  logic          found;
  // scan from last+1 upward, the search wraps so last itself is visited last
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/muxn_rr.sv
// muxn_rr: N-way registered mux, explicit select or round-robin (round-robin only with MUXN_RR_RR_EN)
import mux_pkg::*;
module muxn_rr #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N = DEF_N
) (
  input logic     clk,
  input logic     rst,
  muxn_rr_if.slave bus
);
  localparam int IW = $clog2(N);
  logic             load_en;
  logic [N-1:0]     sel_grant;
  logic [N-1:0]     grant;
  logic [IW-1:0]    gidx;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [IW-1:0]    out_ch;
  assign load_en = !out_valid || bus.out_ready;
  // explicit select: only an in-range, valid channel can be granted
  always_comb begin
    sel_grant = '0;
    for (int i = 0; i < N; i++) sel_grant[i] = bus.in_valid[i] && (bus.sel == IW'(i));
  end
`ifdef MUXN_RR_RR_EN
  logic [N-1:0]  rr_grant;
  logic [IW-1:0] last_grant;
  rr_arbiter #(.N(N)) u_arb (.req(bus.in_valid), .last(last_grant), .grant(rr_grant));
  assign grant = (bus.mode == MODE_RR) ? rr_grant : sel_grant;
  // priority pointer advances only on round-robin transfers
  always_ff @(posedge clk or posedge rst)
    if (rst) last_grant <= IW'(N - 1);
    else if (load_en && |grant && bus.mode == MODE_RR) last_grant <= gidx;
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
  assign grant = sel_grant;
`endif
  // one-hot grant to channel index
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) if (grant[i]) gidx = IW'(i);
  end
  assign bus.in_ready = (load_en && !rst) ? grant : '0;
  // single output register, reloads back-to-back whenever downstream accepts
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
    end else if (load_en) begin
      out_valid <= |grant;
      if (|grant) begin
        out_data <= bus.in_data[gidx];
        out_ch <= gidx;
      end
    end
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_data;
  assign bus.out_ch = out_ch;
endmodule

// File: tb/tb_muxn_rr.sv
// tb_muxn_rr: directed vector table plus reset, hold and round-robin sequences for muxn_rr
module tb_muxn_rr;
  logic clk;
  logic rst;
  int total = 0;
  int bad = 0;
  muxn_rr_if #(.WIDTH(32), .N(4)) bus ();
  muxn_rr_if #(.WIDTH(32), .N(5)) bus5 ();
  muxn_rr #(.WIDTH(32), .N(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  muxn_rr #(.WIDTH(32), .N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] ir;
    logic       ov;
    logic [1:0] ch;
  } vec_t;
  vec_t vecs[11];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask
  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] iv, input logic r);
    @(negedge clk);
    bus.mode = m;
    bus.sel = s;
    bus.in_valid = iv;
    bus.out_ready = r;
    #1;
  endtask
  task automatic post(input string nm, input logic [3:0] ir, input logic ov, input logic [1:0] ch);
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'(ir));
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 32'(bus.out_valid), 32'(ov));
    if (ov) begin
      chk({nm, " out_ch"}, 32'(bus.out_ch), 32'(ch));
      chk({nm, " out_data"}, bus.out_data, 32'hA3 + 32'(ch));
    end
  endtask
  initial begin
    vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[1]  = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[3]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[4]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[5]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[6]  = '{1'b1, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, 2'd2, 4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[8]  = '{1'b0, 2'd2, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2};
    vecs[9]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[10] = '{1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd0};
    for (int i = 0; i < 4; i++) bus.in_data[i] = 32'hA3 + 32'(i);
    for (int i = 0; i < 5; i++) bus5.in_data[i] = 32'hA3 + 32'(i);
    bus.mode = 1'b0;
    bus.sel = 2'd0;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    bus5.mode = 1'b0;
    bus5.sel = 3'd0;
    bus5.in_valid = 5'b00000;
    bus5.out_ready = 1'b1;
    rst = 1'b1;
    #3;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_data", bus.out_data, 32'd0);
    chk("reset out_ch", 32'(bus.out_ch), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].mode, vecs[k].sel, vecs[k].iv, vecs[k].ordy);
      post($sformatf("vec%0d", k), vecs[k].ir, vecs[k].ov, vecs[k].ch);
    end
    drive(1'b0, 2'd1, 4'b0010, 1'b0);
    post("pre-rst load", 4'b0010, 1'b1, 2'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst out_data", bus.out_data, 32'd0);
    chk("midrst out_ch", 32'(bus.out_ch), 32'd0);
    chk("midrst in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    post("post-rst first", 4'b0001, 1'b1, 2'd0);
`ifdef MUXN_RR_RR_EN
    drive(1'b0, 2'd0, 4'b0000, 1'b1);
    post("rr drain", 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'd0, 4'b1111, 1'b1);
      post($sformatf("rr seq%0d", k), 4'(1 << (k % 4)), 1'b1, 2'(k % 4));
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'd0, 4'b1111, 1'b0);
      post($sformatf("rr hold%0d", k), 4'b0000, 1'b1, 2'd0);
    end
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    post("rr release", 4'b0010, 1'b1, 2'd1);
    drive(1'b0, 2'd3, 4'b1000, 1'b1);
    post("sel no ptr move", 4'b1000, 1'b1, 2'd3);
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    post("rr after sel", 4'b0100, 1'b1, 2'd2);
    drive(1'b1, 2'd0, 4'b0000, 1'b1);
    post("rr idle", 4'b0000, 1'b0, 2'd0);
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    post("rr ptr held", 4'b1000, 1'b1, 2'd3);
`else
    drive(1'b1, 2'd1, 4'b1111, 1'b1);
    post("mode ignored sel1", 4'b0010, 1'b1, 2'd1);
    drive(1'b1, 2'd1, 4'b1111, 1'b1);
    post("mode ignored repeat", 4'b0010, 1'b1, 2'd1);
`endif
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus5.sel = 3'd5;
      bus5.in_valid = 5'b11111;
      #1;
      chk($sformatf("sel oob in_ready%0d", k), 32'(bus5.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("sel oob out_valid%0d", k), 32'(bus5.out_valid), 32'd0);
    end
    @(negedge clk);
    bus5.sel = 3'd4;
    #1;
    chk("sel top in_ready", 32'(bus5.in_ready), 32'b10000);
    @(posedge clk);
    #1;
    chk("sel top out_ch", 32'(bus5.out_ch), 32'd4);
    chk("sel top out_data", bus5.out_data, 32'hA7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
